// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FWFT FIFO with registered occupancy, almost-full/empty thresholds and flush.
// Optional sticky overflow/underflow flags are built when FIFO_SYNC_ERR_FLAGS_EN is defined.
module fifo_sync_param #(
    parameter int DATA_W    = 32,
    parameter int N_log     = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_rd_en,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic [N_log:0]    o_words,
    output logic              o_ovfl,
    output logic              o_udfl
);
    localparam int            D    = 1 << N_log;
    localparam logic [N_log:0] C_D  = (N_log+1)'(D);
    localparam logic [N_log:0] C_AF = (N_log+1)'(AF_THRESH);
    localparam logic [N_log:0] C_AE = (N_log+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [D];
    logic [N_log:0]    r_wr_ptr;
    logic [N_log:0]    r_rd_ptr;
    logic [N_log:0]    r_words;
    logic [N_log-1:0]  r_adr_rd;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;

    logic              w_wr_go;
    logic              w_rd_go;
    logic [N_log:0]    w_wr_ptr_nxt;
    logic [N_log:0]    w_rd_ptr_nxt;
    logic [N_log:0]    w_words_nxt;

    assign w_wr_go = i_wr_en & ~r_full  & ~i_flush;
    assign w_rd_go = i_rd_en & ~r_empty & ~i_flush;

    // Flush moves the read pointer onto the write pointer; any write in that cycle is already gated off.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + {{N_log{1'b0}}, w_wr_go};
        w_rd_ptr_nxt = r_rd_ptr + {{N_log{1'b0}}, w_rd_go};
        w_words_nxt  = r_words + {{N_log{1'b0}}, w_wr_go} - {{N_log{1'b0}}, w_rd_go};
        if (i_flush) begin
            w_rd_ptr_nxt = r_wr_ptr;
            w_words_nxt  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_words        <= '0;
            r_adr_rd       <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_words        <= w_words_nxt;
            r_adr_rd       <= w_rd_ptr_nxt[N_log-1:0];
            r_full         <= (w_words_nxt == C_D);
            r_empty        <= (w_words_nxt == '0);
            r_almost_full  <= (w_words_nxt >= C_AF);
            r_almost_empty <= (w_words_nxt <= C_AE);
        end
    end

    // NOTE: storage has no reset so it maps onto distributed RAM; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_mem[r_wr_ptr[N_log-1:0]] <= i_wr_data;
        end
    end

    // Registered read address tracks the post-pop head, so the next word is visible right after a pop.
    assign o_rd_data      = r_mem[r_adr_rd];
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_words        = r_words;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic r_ovfl;
    logic r_udfl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfl <= 1'b0;
            r_udfl <= 1'b0;
        end else begin
            if (i_wr_en & r_full  & ~i_flush) r_ovfl <= 1'b1;
            if (i_rd_en & r_empty & ~i_flush) r_udfl <= 1'b1;
        end
    end

    assign o_ovfl = r_ovfl;
    assign o_udfl = r_udfl;
`else
    assign o_ovfl = 1'b0;
    assign o_udfl = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at default parameters (16 x 32, AF=14, AE=1).
module tb_fifo_sync_param;
    localparam int DATA_W = 32;
    localparam int N_log  = 4;
    localparam int D      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_flush = 1'b0;
    logic [DATA_W-1:0] i_wr_data = '0;
    logic              i_wr_en = 1'b0;
    logic              i_rd_en = 1'b0;
    logic              o_full, o_almost_full, o_empty, o_almost_empty, o_ovfl, o_udfl;
    logic [DATA_W-1:0] o_rd_data;
    logic [N_log:0]    o_words;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovfl = 1'b0;
    logic              m_udfl = 1'b0;

    fifo_sync_param #(.DATA_W(DATA_W), .N_log(N_log), .AF_THRESH(14), .AE_THRESH(1)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_wr_data(i_wr_data), .i_wr_en(i_wr_en), .o_full(o_full), .o_almost_full(o_almost_full),
        .o_rd_data(o_rd_data), .i_rd_en(i_rd_en), .o_empty(o_empty), .o_almost_empty(o_almost_empty),
        .o_words(o_words), .o_ovfl(o_ovfl), .o_udfl(o_udfl)
    );

    always #5 clk = ~clk;

    // Updates the scoreboard from pre-edge model state, drives one clock, returns 1 time unit after the edge.
    task automatic cycle(input logic wr, input logic [DATA_W-1:0] d, input logic rd, input logic fl);
        bit full  = (q.size() == D);
        bit empty = (q.size() == 0);
        bit wr_go = wr && !full && !fl;
        bit rd_go = rd && !empty && !fl;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        if (!fl && wr && full)  m_ovfl = 1'b1;
        if (!fl && rd && empty) m_udfl = 1'b1;
`endif
        if (fl) q.delete();
        else begin
            if (rd_go) void'(q.pop_front());
            if (wr_go) q.push_back(d);
        end
        i_wr_en = wr; i_wr_data = d; i_rd_en = rd; i_flush = fl;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        q.delete(); m_ovfl = 1'b0; m_udfl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
        checks++; if (o_words !== 5'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", o_words); end
        checks++; if (o_almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", o_almost_empty); end
        checks++; if (o_almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", o_almost_full); end
        checks++; if ({o_ovfl, o_udfl} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b%b exp=00", o_ovfl, o_udfl); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill;
        logic [N_log:0] ew;
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0, 1'b0);
            ew = (N_log+1)'(q.size());
            checks++; if (o_words !== ew) begin failures++; $display("FAIL fill_words i=%0d got=%0d exp=%0d", i, o_words, ew); end
            checks++; if (o_full !== (ew == 5'd16)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, o_full, ew == 5'd16); end
            checks++; if (o_almost_full !== (ew >= 5'd14)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, o_almost_full, ew >= 5'd14); end
            checks++; if (o_almost_empty !== (ew <= 5'd1)) begin failures++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, o_almost_empty, ew <= 5'd1); end
            checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, o_empty); end
            checks++; if (o_rd_data !== q[0]) begin failures++; $display("FAIL fill_head i=%0d got=%h exp=%h", i, o_rd_data, q[0]); end
        end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (o_words !== 5'd16) begin failures++; $display("FAIL drop_words got=%0d exp=16", o_words); end
        checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL drop_full got=%b exp=1", o_full); end
        checks++; if (q.size() != D || q[D-1] !== 32'hAF) begin failures++; $display("FAIL drop_model size=%0d exp=16", q.size()); end
    endtask

    task automatic test_drain;
        logic [DATA_W-1:0] exp_d;
        logic [N_log:0]    ew;
        for (int i = 0; i < D; i++) begin
            exp_d = q[0];
            checks++; if (o_rd_data !== exp_d) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, o_rd_data, exp_d); end
            cycle(1'b0, '0, 1'b1, 1'b0);
            ew = (N_log+1)'(q.size());
            checks++; if (o_words !== ew) begin failures++; $display("FAIL drain_words i=%0d got=%0d exp=%0d", i, o_words, ew); end
            checks++; if (o_empty !== (ew == 5'd0)) begin failures++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, o_empty, ew == 5'd0); end
            checks++; if (o_almost_empty !== (ew <= 5'd1)) begin failures++; $display("FAIL drain_ae i=%0d got=%b exp=%b", i, o_almost_empty, ew <= 5'd1); end
            checks++; if (o_almost_full !== (ew >= 5'd14)) begin failures++; $display("FAIL drain_af i=%0d got=%b exp=%b", i, o_almost_full, ew >= 5'd14); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(32'hB0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DATA_W'(32'hC000 + i), 1'b1, 1'b0);
            checks++; if (o_words !== 5'd3) begin failures++; $display("FAIL b2b_words i=%0d got=%0d exp=3", i, o_words); end
            checks++; if (o_rd_data !== q[0]) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, o_rd_data, q[0]); end
            checks++; if (o_almost_empty !== 1'b0 || o_almost_full !== 1'b0) begin failures++; $display("FAIL b2b_flags i=%0d got=%b%b exp=00", i, o_almost_empty, o_almost_full); end
        end
        while (q.size() > 0) begin
            checks++; if (o_rd_data !== q[0]) begin failures++; $display("FAIL b2b_tail got=%h exp=%h", o_rd_data, q[0]); end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_write_empty_pop;
        cycle(1'b1, 32'h0000_005A, 1'b1, 1'b0);
        checks++; if (o_words !== 5'd1) begin failures++; $display("FAIL wep_words got=%0d exp=1", o_words); end
        checks++; if (o_rd_data !== 32'h5A) begin failures++; $display("FAIL wep_data got=%h exp=0000005a", o_rd_data); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_empty !== 1'b1 || o_words !== 5'd0) begin failures++; $display("FAIL wep_pop got=%b/%0d exp=1/0", o_empty, o_words); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(32'hF0 + i), 1'b0, 1'b0);
        checks++; if (o_words !== 5'd5) begin failures++; $display("FAIL flush_pre got=%0d exp=5", o_words); end
        cycle(1'b1, 32'h77, 1'b0, 1'b1);
        checks++; if (o_words !== 5'd0) begin failures++; $display("FAIL flush_words got=%0d exp=0", o_words); end
        checks++; if (o_empty !== 1'b1 || o_almost_empty !== 1'b1) begin failures++; $display("FAIL flush_flags got=%b%b exp=11", o_empty, o_almost_empty); end
        cycle(1'b1, 32'h88, 1'b0, 1'b0);
        checks++; if (o_words !== 5'd1) begin failures++; $display("FAIL flush_after_words got=%0d exp=1", o_words); end
        checks++; if (o_rd_data !== 32'h88) begin failures++; $display("FAIL flush_after_data got=%h exp=00000088", o_rd_data); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL flush_drain got=%b exp=1", o_empty); end
    endtask

    task automatic test_err_flags;
        for (int i = 0; i < D; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h1234, 1'b0, 1'b0);
        checks++; if (o_ovfl !== m_ovfl) begin failures++; $display("FAIL ovfl_set got=%b exp=%b", o_ovfl, m_ovfl); end
        checks++; if (o_full !== 1'b1 || o_rd_data !== 32'h0) begin failures++; $display("FAIL ovfl_drop got=%b/%h exp=1/0", o_full, o_rd_data); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++; if (o_ovfl !== m_ovfl) begin failures++; $display("FAIL ovfl_hold got=%b exp=%b", o_ovfl, m_ovfl); end
        checks++; if (o_udfl !== 1'b0) begin failures++; $display("FAIL udfl_early got=%b exp=0", o_udfl); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (o_udfl !== m_udfl) begin failures++; $display("FAIL udfl_set got=%b exp=%b", o_udfl, m_udfl); end
        checks++; if (o_words !== 5'd0 || o_empty !== 1'b1) begin failures++; $display("FAIL udfl_state got=%0d/%b exp=0/1", o_words, o_empty); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(32'hE0 + i), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete(); m_ovfl = 1'b0; m_udfl = 1'b0;
        checks++; if (o_words !== 5'd0) begin failures++; $display("FAIL arst_words got=%0d exp=0", o_words); end
        checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin failures++; $display("FAIL arst_ef got=%b%b exp=10", o_empty, o_full); end
        checks++; if (o_almost_empty !== 1'b1 || o_almost_full !== 1'b0) begin failures++; $display("FAIL arst_almost got=%b%b exp=10", o_almost_empty, o_almost_full); end
        checks++; if ({o_ovfl, o_udfl} !== 2'b00) begin failures++; $display("FAIL arst_err got=%b%b exp=00", o_ovfl, o_udfl); end
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        checks++; if (o_rd_data !== 32'h0BAD_F00D || o_words !== 5'd1) begin failures++; $display("FAIL arst_after got=%h/%0d exp=0badf00d/1", o_rd_data, o_words); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_write_empty_pop();
        test_flush();
        test_err_flags();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
